qc_ldpc_encoder: RTL and testbench
==================================

// Module: qc_ldpc_encoder
// PURPOSE
//  Systematic QC-LDPC encoder; the transmit-side counterpart of the iterative decoder top.
//  Accepts a message one D-bit circulant block per handshake and forwards it unchanged (registered).
//  Meanwhile accumulates PB parity blocks from a weight-1 circulant parity-generator shift table,
//  then emits them. Codeword = KB message blocks then PB parity blocks (N=(KB+PB)*D).
// PARAMETERS
//  data_w  8   width of one shift entry in gmtx
//  D       64  circulant size (bits per block)
//  KB      16  message blocks per codeword
//  PB      16  parity blocks per codeword
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset, asynchronous, active-high
//  gmtx       in   KB*PB*data_w   shift of circulant (kb,pb) at [(kb*PB+pb)*data_w +: data_w]; stable per codeword
//  in_data    in   D              message block
//  in_valid   in   1              in_data valid
//  in_ready   out  1              encoder accepts in_data this cycle
//  out_data   out  D              codeword block
//  out_valid  out  1              out_data valid
//  out_ready  in   1              sink accepts out_data this cycle
//  out_last   out  1              high with final parity block of codeword
//  busy       out  1              codeword in progress (blk_cnt!=0 or state==S_PAR)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-codeword): state=S_MSG, blk_cnt=0, parity regs=0,
//    out_valid=0, out_data=0, out_last=0, in_ready=0 during rst; partial codeword discarded.
//  - Handshakes: transfer iff valid&&ready on rising clk. out_data/out_valid/out_last registered,
//    held stable while out_valid&&!out_ready. in_ready never depends combinationally on in_valid.
//  - S_MSG: in_ready = !out_valid || out_ready. On accept of block kb=blk_cnt:
//    out_data<=in_data, out_valid<=1, out_last<=0;
//    for every pb in parallel: par[pb] <= par[pb] ^ rot(in_data, s(kb,pb)).
//    kb==KB-1 -> blk_cnt<=0, state<=S_PAR; else blk_cnt++.
//  - rot(m,s): for s<D result bit (k+s) mod D = m[k] (rotate toward MSB by s);
//    s>=D (incl. all-ones 2^data_w-1) = zero circulant, contributes 0.
//  - S_PAR: in_ready=0. When !out_valid||out_ready: out_data<=par[blk_cnt], out_valid<=1,
//    out_last<=(blk_cnt==PB-1). After loading pb=PB-1: par all <=0, blk_cnt<=0, state<=S_MSG.
//  - Latency: first message block appears on out_data 1 cycle after accept. First parity
//    block loads the cycle after the last message block transfers out (no bubble under
//    continuous out_ready): steady-state throughput KB+PB cycles per codeword.
//  - Idle: out_valid drops to 0 after a transfer with no new load.
//  - Back-pressure: out_ready=0 stalls in S_MSG (in_ready=0) and S_PAR; no data lost/duplicated.
//  - Next codeword's first block accepted in the same cycle the out_last block transfers.
//  - blk_cnt width $clog2(max(KB,PB)); never exceeds max(KB,PB)-1.
//  - gmtx sampled combinationally at each message accept; changing it mid-codeword is not supported.
// STRUCTURE
//  - ldpc_pkg: state enum {S_MSG,S_PAR}; function circ_shift_valid(s,D); default D/data_w
//    constants shared with the decoder and check block.
//  - Sub-module circ_rotate #(D,data_w) (m, s -> r): barrel rotator with zero-circulant
//    sentinel; PB instances, row-selected by blk_cnt via gmtx mux.
//  - Top: FSM + blk_cnt, PB x D parity register file, output register stage.
// TESTING
//  1 rst mid-S_MSG after 5 blocks -> out_valid=0, par=0; next codeword parity equals clean run.
//  2 all gmtx shifts=0, D=64,KB=PB=16, msg blocks all 1 -> 16 msg blocks then 16 parity=0 (even count).
//  3 gmtx shift(0,0)=3, all else 8'hFF; msg block0=64'h1, others 0 -> par[0]=64'h8, par[1..15]=0, out_last on block 31.
//  4 random gmtx/msg, out_ready held 1 -> 32 back-to-back beats, parity matches software model;
//    cross-check: decoder top driven with the codeword returns it with err=0.
//  5 out_ready random 30% duty, in_valid random -> stream identical to test 4, out_data stable while stalled.
//  6 two codewords back-to-back -> block0 of cw2 accepted same cycle as cw1 out_last transfer; par cleared.

Source files
------------

// File: rtl/qc_ldpc_encoder_pkg.sv
// Shared QC-LDPC definitions: default code geometry, encoder state encoding and
// the zero-circulant shift test used by the rotators.
package qc_ldpc_encoder_pkg;

    localparam int LDPC_D      = 64;
    localparam int LDPC_DATA_W = 8;
    localparam int LDPC_KB     = 16;
    localparam int LDPC_PB     = 16;

    typedef enum logic {
        S_MSG,
        S_PAR
    } enc_state_e;

    // Any shift at or beyond the circulant size marks an all-zero circulant.
    function automatic logic circ_shift_valid(input int s, input int d);
        return s < d;
    endfunction

endpackage

// File: rtl/qc_ldpc_encoder_circ_rotate.sv
// Barrel rotator for one weight-1 circulant: r[(k+s) mod D] = m[k], or all zero
// when the shift is the zero-circulant sentinel (s >= D).
module circ_rotate
    import qc_ldpc_encoder_pkg::*;
#(
    parameter int D      = LDPC_D,
    parameter int data_w = LDPC_DATA_W
) (
    input  logic [D-1:0]      m,
    input  logic [data_w-1:0] s,
    output logic [D-1:0]      r
);

    always_comb begin
        r = '0;
        if (circ_shift_valid(int'(32'(s)), D)) begin
            r = D'(({m, m} << s) >> D);
        end
    end

endmodule

// File: rtl/qc_ldpc_encoder.sv
// Systematic QC-LDPC encoder: passes message blocks through a registered output
// stage while accumulating parity blocks, then streams the parity blocks out.
module qc_ldpc_encoder
    import qc_ldpc_encoder_pkg::*;
#(
    parameter int data_w = LDPC_DATA_W,
    parameter int D      = LDPC_D,
    parameter int KB     = LDPC_KB,
    parameter int PB     = LDPC_PB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KB*PB*data_w-1:0]  gmtx,
    input  logic [D-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [D-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);

    localparam int CNT_MAX = (KB > PB) ? KB : PB;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    enc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [D-1:0]      par_q [PB];
    logic [D-1:0]      par_d [PB];
    logic [D-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [data_w-1:0] shift_sel [PB];
    logic [D-1:0]      rot      [PB];
    logic              out_free;
    logic              accept;

    // Row kb = blk_cnt of the shift table feeds all PB rotators at once.
    always_comb begin
        for (int pb = 0; pb < PB; pb++) begin
            shift_sel[pb] = gmtx[(int'(blk_cnt_q) * PB + pb) * data_w +: data_w];
        end
    end

    for (genvar g = 0; g < PB; g++) begin : g_rot
        circ_rotate #(.D(D), .data_w(data_w)) u_rot (
            .m (in_data),
            .s (shift_sel[g]),
            .r (rot[g])
        );
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !rst && (state_q == S_MSG) && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        blk_cnt_d   = blk_cnt_q;
        par_d       = par_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q;

        case (state_q)
            S_MSG: begin
                if (accept) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    for (int pb = 0; pb < PB; pb++) begin
                        par_d[pb] = par_q[pb] ^ rot[pb];
                    end
                    if (blk_cnt_q == CNT_W'(KB - 1)) begin
                        blk_cnt_d = '0;
                        state_d   = S_PAR;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (out_free) begin
                    out_data_d  = par_q[blk_cnt_q];
                    out_valid_d = 1'b1;
                    out_last_d  = (blk_cnt_q == CNT_W'(PB - 1));
                    if (blk_cnt_q == CNT_W'(PB - 1)) begin
                        for (int pb = 0; pb < PB; pb++) begin
                            par_d[pb] = '0;
                        end
                        blk_cnt_d = '0;
                        state_d   = S_MSG;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_MSG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_MSG;
            blk_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int pb = 0; pb < PB; pb++) begin
                par_q[pb] <= '0;
            end
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            par_q       <= par_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (blk_cnt_q != '0) || (state_q == S_PAR);

endmodule

// File: tb/tb_qc_ldpc_encoder.sv
// Directed bench for qc_ldpc_encoder at D=64, KB=PB=16, data_w=8.
module tb_qc_ldpc_encoder;

    localparam int DW = 8;
    localparam int D  = 64;
    localparam int KB = 16;
    localparam int PB = 16;
    localparam int CW = KB + PB;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [KB*PB*DW-1:0]    gmtx = '0;
    logic [D-1:0]           in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [D-1:0]           out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   out_last;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] msg     [2*KB];
    logic [D-1:0] exp_out [2*CW];

    qc_ldpc_encoder #(.data_w(DW), .D(D), .KB(KB), .PB(PB)) dut (
        .clk       (clk),
        .rst       (rst),
        .gmtx      (gmtx),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int i = 0; i < KB * PB; i++) gmtx[i*DW +: DW] = v;
    endtask

    task automatic set_shift(input int kb, input int pb, input logic [DW-1:0] v);
        gmtx[(kb*PB + pb)*DW +: DW] = v;
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 2*KB; i++) msg[i] = '0;
        for (int i = 0; i < 2*CW; i++) exp_out[i] = '0;
    endtask

    // Streams ncw codewords from msg[], comparing every output beat to exp_out[].
    task automatic run(input string tag, input int ncw, input bit rnd);
        int mi = 0;
        int bi = 0;
        int it = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [D-1:0] pd = '0;
        while (bi < ncw*CW && it < 3000) begin
            @(negedge clk);
            it++;
            if (pv && !pr) chk({tag, "_stall_hold"}, out_data, pd);
            out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            in_valid  = (mi < ncw*KB) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_data   = (mi < ncw*KB) ? msg[mi] : '0;
            #1;
            if (out_valid && out_ready) begin
                chk({tag, "_data"}, out_data, exp_out[bi]);
                chk({tag, "_last"}, 64'(out_last), 64'((bi % CW) == CW - 1));
                if (bi == CW - 1 && ncw > 1) chk({tag, "_next_accept"}, 64'(in_ready && in_valid), 64'd1);
                bi++;
            end
            if (in_valid && in_ready) mi++;
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
        chk({tag, "_beats"}, 64'(bi), 64'(ncw*CW));
        if (!rnd) chk({tag, "_cycles"}, 64'(it), 64'(ncw*CW + 1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic load_shift_pb_pattern();
        // shift(kb,pb)=pb with message kb = 1<<kb gives par[pb] = 16'hFFFF << pb
        set_all('0);
        for (int kb = 0; kb < KB; kb++)
            for (int pb = 0; pb < PB; pb++) set_shift(kb, pb, DW'(pb));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // all shifts 0, all-ones messages: even count of ones cancels
        set_all('0);
        clear_vec();
        for (int i = 0; i < KB; i++) begin
            msg[i] = '1;
            exp_out[i] = '1;
        end
        run("zero_shift", 1, 1'b0);

        // reset in the middle of a codeword, then a clean codeword
        set_all(8'hFF);
        set_shift(0, 0, 8'd3);
        clear_vec();
        msg[0] = 64'h1;
        exp_out[0] = 64'h1;
        exp_out[KB] = 64'h8;
        out_ready = 1'b1;
        in_data   = 64'h1;
        in_valid  = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("single_bit", 1, 1'b0);

        // wrap at shift 63, zero circulant at shift 64
        set_all(8'hFF);
        set_shift(0, 0, 8'd63);
        set_shift(0, 1, 8'd64);
        set_shift(1, 2, 8'd1);
        clear_vec();
        msg[0] = 64'h8000_0000_0000_0001;
        msg[1] = 64'h8000_0000_0000_0000;
        exp_out[0] = msg[0];
        exp_out[1] = msg[1];
        exp_out[KB]   = 64'hC000_0000_0000_0000;
        exp_out[KB+1] = 64'h0;
        exp_out[KB+2] = 64'h1;
        run("wrap", 1, 1'b0);

        // diagonal pattern under random back-pressure and input gaps
        load_shift_pb_pattern();
        clear_vec();
        for (int kb = 0; kb < KB; kb++) begin
            msg[kb] = 64'h1 << kb;
            exp_out[kb] = 64'h1 << kb;
        end
        for (int pb = 0; pb < PB; pb++) exp_out[KB+pb] = 64'hFFFF << pb;
        run("backpressure", 1, 1'b1);

        // two codewords back to back; second parity proves the clear
        for (int kb = 0; kb < KB; kb++) begin
            msg[KB+kb] = 64'h1 << (kb + 16);
            exp_out[CW+kb] = 64'h1 << (kb + 16);
        end
        for (int pb = 0; pb < PB; pb++) exp_out[CW+KB+pb] = 64'hFFFF << (pb + 16);
        run("two_cw", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
